// File: rtl/vga_pkg.sv
// Shared framebuffer definitions: frame geometry, pixel word layout,
// read-return tags and clear engine states.
package vga_pkg;

  localparam int FB_DEPTH = 307200;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Pixel word: 12-bit RGB packed into the low bits of a 16-bit word.
  localparam int PIX_W       = 16;
  localparam int RGB_FIELD_W = 4;
  localparam int RGB_R_LSB   = 8;
  localparam int RGB_G_LSB   = 4;
  localparam int RGB_B_LSB   = 0;

  typedef logic [PIX_W-1:0] pixel_t;

  // Identifies who owns a read that is travelling through the RAM pipeline.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } rd_tag_t;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/vga_fb_clear_engine.sv
// Frame clear engine: walks every framebuffer address once, writing a
// latched fill colour whenever the arbiter hands it an idle RAM cycle.
module vga_fb_clear_engine #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int FB_DEPTH = vga_pkg::FB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] color,
  input  logic              grant,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] fill_color
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  clr_state_t        state_q;
  clr_state_t        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] color_q;
  logic              done_q;
  logic              last_grant;

  assign last_grant = (state_q == CLR_RUN) && grant && (addr_q == LAST_ADDR);

  // State register; a reset mid-clear simply drops back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLR_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start is only honoured from IDLE, RUN ends on the last grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLR_IDLE: if (start)      state_d = CLR_RUN;
      CLR_RUN:  if (last_grant) state_d = CLR_IDLE;
      default:                  state_d = CLR_IDLE;
    endcase
  end

  // Address walk, colour capture and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_grant;
      if ((state_q == CLR_IDLE) && start) begin
        addr_q  <= '0;
        color_q <= color;
      end else if ((state_q == CLR_RUN) && grant && !last_grant) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign busy       = (state_q == CLR_RUN);
  assign done       = done_q;
  assign addr       = addr_q;
  assign fill_color = color_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch, CPU port and clear engine share a
// single-port synchronous RAM. Display has deadline priority, the CPU is
// protected from starvation, and the clear engine soaks up idle cycles.
module vga_fb_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int FB_DEPTH = vga_pkg::FB_DEPTH,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [15:0]       disp_stall_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import vga_pkg::*;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt;
  logic              clr_gnt;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color;
  rd_tag_t           tag_issue;
  rd_tag_t           tag_q1;
  rd_tag_t           tag_q2;
  logic [DATA_W-1:0] disp_hold_q;
  logic [DATA_W-1:0] cpu_hold_q;

  vga_fb_clear_engine #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .FB_DEPTH (FB_DEPTH)
  ) u_clear (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (clear_start),
    .color      (clear_color),
    .grant      (clr_gnt),
    .busy       (clear_busy),
    .done       (clear_done),
    .addr       (clr_addr),
    .fill_color (clr_color)
  );

  // Pick at most one winner per cycle; a starved CPU jumps the display.
  always_comb begin
    disp_gnt  = 1'b0;
    cpu_ready = 1'b0;
    clr_gnt   = 1'b0;
    tag_issue = TAG_NONE;
    if (cpu_valid && (wait_cnt == WAIT_LIMIT)) cpu_ready = 1'b1;
    else if (disp_req)                         disp_gnt  = 1'b1;
    else if (cpu_valid)                        cpu_ready = 1'b1;
    else if (clear_busy)                       clr_gnt   = 1'b1;
    if (disp_gnt)                  tag_issue = TAG_DISP;
    else if (cpu_ready && !cpu_we) tag_issue = TAG_CPU;
  end

  // CPU starvation counter: counts stalled cycles of a pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= '0;
    else if (!cpu_valid || cpu_ready) wait_cnt <= '0;
    else if (wait_cnt < WAIT_LIMIT)  wait_cnt <= wait_cnt + 8'd1;
  end

  // Saturating count of cycles the display was left waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                disp_stall_cnt <= '0;
    else if (disp_req && !disp_gnt && (disp_stall_cnt != 16'hFFFF)) disp_stall_cnt <= disp_stall_cnt + 16'd1;
  end

  // Issue stage: register the winner's access onto the RAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= disp_gnt || cpu_ready || clr_gnt;
      mem_we <= (cpu_ready && cpu_we) || clr_gnt;
      if (disp_gnt) begin
        mem_addr <= disp_addr;
      end else if (cpu_ready) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (clr_gnt) begin
        mem_addr  <= clr_addr;
        mem_wdata <= clr_color;
      end
    end
  end

  // Read tags follow the RAM latency; return data is held after its pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q1      <= TAG_NONE;
      tag_q2      <= TAG_NONE;
      disp_hold_q <= '0;
      cpu_hold_q  <= '0;
    end else begin
      tag_q1 <= tag_issue;
      tag_q2 <= tag_q1;
      if (tag_q2 == TAG_DISP) disp_hold_q <= mem_rdata;
      if (tag_q2 == TAG_CPU)  cpu_hold_q  <= mem_rdata;
    end
  end

  assign disp_rvalid = (tag_q2 == TAG_DISP);
  assign cpu_rvalid  = (tag_q2 == TAG_CPU);
  assign disp_rdata  = disp_rvalid ? mem_rdata : disp_hold_q;
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_hold_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a behavioural model.
module tb_vga_fb_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 16;
  localparam int FB_DEPTH = 16;
  localparam int MAX_WAIT = 8;
  localparam int RAM_SZ   = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic [15:0]       disp_stall_cnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .FB_DEPTH (FB_DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_gnt       (disp_gnt),
    .disp_rvalid    (disp_rvalid),
    .disp_rdata     (disp_rdata),
    .cpu_valid      (cpu_valid),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ready      (cpu_ready),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .clear_start    (clear_start),
    .clear_color    (clear_color),
    .clear_busy     (clear_busy),
    .clear_done     (clear_done),
    .disp_stall_cnt (disp_stall_cnt),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Content of a RAM word that has never been written.
  function automatic logic [15:0] ramDefault(input int a);
    return 16'((a * 37) + 16'h1234);
  endfunction

  // Environment RAM: synchronous single port, read data one cycle after enable.
  logic [15:0] ram [0:RAM_SZ-1];
  bit          ram_valid [0:RAM_SZ-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[9:0]]       <= mem_wdata;
        ram_valid[mem_addr[9:0]] <= 1'b1;
      end else begin
        mem_rdata <= ram_valid[mem_addr[9:0]] ? ram[mem_addr[9:0]] : ramDefault(int'(mem_addr[9:0]));
      end
    end
  end

  // Reference model state.
  typedef struct {
    int          due;
    bit          is_cpu;
    logic [15:0] data;
  } rd_t;

  logic [15:0] model_mem [0:RAM_SZ-1];
  bit          model_valid [0:RAM_SZ-1];
  rd_t         rdq[$];
  int          cyc;
  int          stall;
  int          dstall;
  bit          clr_active;
  int          clr_next;
  logic [15:0] clr_col;
  bit          done_due;
  bit          exp_en;
  bit          exp_we;
  logic [18:0] exp_addr;
  logic [15:0] exp_wdata;
  bit          last_g_disp;
  bit          last_g_cpu;

  bit          obs_disp_gnt;
  bit          obs_cpu_ready;
  bit          obs_cpu_rvalid;
  logic [15:0] obs_cpu_rdata;
  bit          obs_clear_done;
  bit          obs_wr;
  int          obs_wr_addr;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] modelRead(input int a);
    return model_valid[a] ? model_mem[a] : ramDefault(a);
  endfunction

  task automatic modelReset();
    rdq.delete();
    stall       = 0;
    dstall      = 0;
    clr_active  = 0;
    clr_next    = 0;
    clr_col     = '0;
    done_due    = 0;
    exp_en      = 0;
    exp_we      = 0;
    exp_addr    = '0;
    exp_wdata   = '0;
    last_g_disp = 0;
    last_g_cpu  = 0;
  endtask

  task automatic setIdle();
    disp_req    = 1'b0;
    disp_addr   = '0;
    cpu_valid   = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    clear_start = 1'b0;
    clear_color = '0;
  endtask

  // Randomized traffic; a request that was not granted is held unchanged.
  task automatic applyStimulus(input int disp_pct, input int cpu_pct);
    if (!(disp_req && !last_g_disp)) begin
      disp_req  = ($urandom_range(0, 99) < disp_pct);
      disp_addr = 19'($urandom_range(0, 31));
    end
    if (!(cpu_valid && !last_g_cpu)) begin
      cpu_valid = ($urandom_range(0, 99) < cpu_pct);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 19'($urandom_range(0, 31));
      cpu_wdata = 16'($urandom);
    end
    clear_start = ($urandom_range(0, 99) < 2);
    clear_color = 16'($urandom);
  endtask

  // One clock cycle: check DUT against the model mid-cycle, then advance the model.
  task automatic runCycle();
    bit          g_cpu, g_disp, g_clr, due_d, due_c, was_active;
    logic [15:0] exp_data;
    rd_t         r;
    @(negedge clk);
    g_cpu  = cpu_valid && ((stall == MAX_WAIT) || !disp_req);
    g_disp = disp_req && !g_cpu;
    g_clr  = clr_active && !disp_req && !cpu_valid;
    checkOutput("disp_gnt", disp_gnt, g_disp);
    checkOutput("cpu_ready", cpu_ready, g_cpu);
    checkOutput("clear_busy", clear_busy, clr_active);
    checkOutput("clear_done", clear_done, done_due);
    checkOutput("disp_stall_cnt", disp_stall_cnt, dstall);
    checkOutput("mem_en", mem_en, exp_en);
    if (exp_en) begin
      checkOutput("mem_we", mem_we, exp_we);
      checkOutput("mem_addr", mem_addr, exp_addr);
      if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
    end
    due_d    = 0;
    due_c    = 0;
    exp_data = '0;
    if ((rdq.size() != 0) && (rdq[0].due == cyc)) begin
      if (rdq[0].is_cpu) due_c = 1;
      else               due_d = 1;
      exp_data = rdq[0].data;
      void'(rdq.pop_front());
    end
    checkOutput("disp_rvalid", disp_rvalid, due_d);
    checkOutput("cpu_rvalid", cpu_rvalid, due_c);
    if (due_d) checkOutput("disp_rdata", disp_rdata, exp_data);
    if (due_c) checkOutput("cpu_rdata", cpu_rdata, exp_data);

    obs_disp_gnt   = disp_gnt;
    obs_cpu_ready  = cpu_ready;
    obs_cpu_rvalid = cpu_rvalid;
    obs_cpu_rdata  = cpu_rdata;
    obs_clear_done = clear_done;
    obs_wr         = mem_en && mem_we;
    obs_wr_addr    = int'(mem_addr);

    if (disp_req && !g_disp && (dstall < 65535)) dstall++;
    if (cpu_valid && !g_cpu) stall = (stall < MAX_WAIT) ? stall + 1 : MAX_WAIT;
    else                     stall = 0;
    exp_en = g_disp || g_cpu || g_clr;
    exp_we = 0;
    if (g_disp) begin
      exp_addr = disp_addr;
      r.due = cyc + 2; r.is_cpu = 0; r.data = modelRead(int'(disp_addr[9:0]));
      rdq.push_back(r);
    end else if (g_cpu) begin
      exp_addr  = cpu_addr;
      exp_we    = cpu_we;
      exp_wdata = cpu_wdata;
      if (cpu_we) begin
        model_mem[cpu_addr[9:0]]   = cpu_wdata;
        model_valid[cpu_addr[9:0]] = 1;
      end else begin
        r.due = cyc + 2; r.is_cpu = 1; r.data = modelRead(int'(cpu_addr[9:0]));
        rdq.push_back(r);
      end
    end else if (g_clr) begin
      exp_addr              = 19'(clr_next);
      exp_we                = 1;
      exp_wdata             = clr_col;
      model_mem[clr_next]   = clr_col;
      model_valid[clr_next] = 1;
      clr_next++;
    end
    was_active = clr_active;
    done_due   = g_clr && (clr_next == FB_DEPTH);
    if (done_due) clr_active = 0;
    if (!was_active && clear_start) begin
      clr_active = 1;
      clr_next   = 0;
      clr_col    = clear_color;
    end
    last_g_disp = g_disp;
    last_g_cpu  = g_cpu;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    setIdle();
    #1;
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_clear_busy", clear_busy, 0);
    checkOutput("rst_clear_done", clear_done, 0);
    checkOutput("rst_disp_rvalid", disp_rvalid, 0);
    checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("rst_stall_cnt", disp_stall_cnt, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int n, cnt, done_cnt;
  bit found;
  logic [15:0] got;
  int wr_cnt [0:FB_DEPTH-1];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cyc = 0;
    modelReset();
    setIdle();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_disp_gnt", disp_gnt, 0);
    checkOutput("rst_cpu_ready", cpu_ready, 0);
    checkOutput("rst_clear_busy", clear_busy, 0);
    checkOutput("rst_stall_cnt", disp_stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] display-only burst");
    for (int i = 0; i < 4; i++) begin
      disp_req  = 1'b1;
      disp_addr = 19'(i);
      runCycle();
      checkOutput("disp_only_gnt", obs_disp_gnt, 1);
    end
    setIdle();
    repeat (3) runCycle();

    $display("[TB] CPU starvation under display load");
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h100;
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      disp_req  = 1'b1;
      disp_addr = 19'(i);
      runCycle();
      n++;
      if (obs_cpu_ready) found = 1;
    end
    checkOutput("starve_ready_cycle", n, 9);
    setIdle();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      runCycle();
      if (obs_cpu_rvalid) cnt++;
    end
    checkOutput("starve_stall_cnt", disp_stall_cnt, 1);
    checkOutput("starve_rvalid_cnt", cnt, 1);

    $display("[TB] CPU write then read");
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd5; cpu_wdata = 16'h0ABC;
    runCycle();
    checkOutput("wr_accept", obs_cpu_ready, 1);
    cpu_we = 1'b0;
    runCycle();
    checkOutput("rd_accept", obs_cpu_ready, 1);
    setIdle();
    cnt = 0; got = '0;
    for (int i = 0; i < 4; i++) begin
      runCycle();
      if (obs_cpu_rvalid) begin cnt++; got = obs_cpu_rdata; end
    end
    checkOutput("wr_rd_count", cnt, 1);
    checkOutput("wr_rd_data", got, 16'h0ABC);

    $display("[TB] reset during clear");
    clear_start = 1'b1; clear_color = 16'h0123;
    runCycle();
    clear_start = 1'b0;
    for (int i = 0; i < 40 && clr_next != 7; i++) runCycle();
    checkOutput("midclear_reach", clr_next, 7);
    doReset();
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      runCycle();
      if (obs_clear_done) done_cnt++;
    end
    checkOutput("midclear_no_done", done_cnt, 0);

    $display("[TB] full clear, restart ignored");
    for (int i = 0; i < FB_DEPTH; i++) wr_cnt[i] = 0;
    clear_start = 1'b1; clear_color = 16'h0F00;
    runCycle();
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      clear_start = (i == 4);
      clear_color = 16'h00FF;
      runCycle();
      if (obs_wr && obs_wr_addr < FB_DEPTH) wr_cnt[obs_wr_addr]++;
      if (obs_clear_done) done_cnt++;
    end
    setIdle();
    checkOutput("clear_done_pulses", done_cnt, 1);
    for (int i = 0; i < FB_DEPTH; i++) checkOutput($sformatf("clear_wr_%0d", i), wr_cnt[i], 1);

    $display("[TB] clear under display contention");
    for (int i = 0; i < FB_DEPTH; i++) wr_cnt[i] = 0;
    clear_start = 1'b1; clear_color = 16'h0055;
    runCycle();
    done_cnt = 0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      applyStimulus(60, 0);
      clear_start = 1'b0;
      runCycle();
      if (obs_wr && obs_wr_addr < FB_DEPTH) wr_cnt[obs_wr_addr]++;
      if (obs_clear_done) done_cnt++;
    end
    setIdle();
    repeat (3) runCycle();
    checkOutput("contend_done", done_cnt, 1);
    for (int i = 0; i < FB_DEPTH; i++) checkOutput($sformatf("contend_wr_%0d", i), wr_cnt[i], 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(40, 35);
      runCycle();
    end
    setIdle();
    repeat (5) runCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Arbitrates one single-port synchronous framebuffer RAM between three requesters: the VGA display fetch path, a CPU read/write port, and an internal clear engine.
- The clear engine fills the whole frame with one colour.
- Display fetch has deadline priority. The CPU gets bounded-latency access through a starvation counter. The clear engine uses only idle cycles.
- Sits between the VGA timing/pixel path, the system bus adapter and the framebuffer RAM.

Parameters:
- ADDR_W, 19, word address width into framebuffer.
- DATA_W, 16, pixel word width (12-bit RGB in bits [11:0]).
- FB_DEPTH, 307200, framebuffer words (640x480); clear engine range 0..FB_DEPTH-1.
- MAX_WAIT, 8, stalled CPU cycles after which the CPU overrides display priority; legal range 1..255.

Ports:
- clk in 1 system clock
- rst_n in 1 asynchronous active-low reset
- disp_req in 1 display fetch request; held until granted
- disp_addr in ADDR_W display fetch address
- disp_gnt out 1 combinational grant to display this cycle
- disp_rvalid out 1 display read data valid
- disp_rdata out DATA_W display read data
- cpu_valid in 1 CPU request valid
- cpu_we in 1 CPU write (1) / read (0)
- cpu_addr in ADDR_W CPU address
- cpu_wdata in DATA_W CPU write data
- cpu_ready out 1 combinational accept; transfer when cpu_valid&&cpu_ready
- cpu_rvalid out 1 CPU read data valid
- cpu_rdata out DATA_W CPU read data
- clear_start in 1 pulse: begin frame clear
- clear_color in DATA_W fill value, sampled on accepted clear_start
- clear_busy out 1 clear in progress
- clear_done out 1 one-cycle pulse after last clear write is issued
- disp_stall_cnt out 16 saturating count of cycles with disp_req&&!disp_gnt; cleared only by reset
- mem_en out 1 RAM enable (registered)
- mem_we out 1 RAM write enable (registered)
- mem_addr out ADDR_W RAM address (registered)
- mem_wdata out DATA_W RAM write data (registered)
- mem_rdata in DATA_W RAM read data, valid one cycle after mem_en&&!mem_we

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; clear FSM in IDLE.
  - Starvation counter, disp_stall_cnt, clear address and read-tag pipeline all 0.
  - Reset mid-clear aborts the clear; no clear_done.
- Arbitration (combinational each cycle, exactly one winner or none), priority:
  - (1) CPU if cpu_valid && wait_cnt==MAX_WAIT;
  - (2) display if disp_req;
  - (3) CPU if cpu_valid;
  - (4) clear engine if clear_busy.
  - disp_gnt and cpu_ready reflect the winner; they are never both 1.
- Starvation counter wait_cnt (8 bit):
  - +1 on each cycle cpu_valid && !cpu_ready;
  - 0 when the CPU is granted or cpu_valid is low;
  - saturates at MAX_WAIT.
- Issue stage (grant in cycle N) registers mem_en/mem_we/mem_addr/mem_wdata at edge ending N:
  - display: we=0;
  - CPU: we=cpu_we, wdata=cpu_wdata;
  - clear: we=1, addr=clear_addr, wdata=latched colour;
  - no winner: mem_en=0.
- Read return:
  - A 2-bit tag (DISP/CPU) travels with the issue; RAM data returns in cycle N+2.
  - In N+2: disp_rvalid or cpu_rvalid is pulsed and the matching rdata is registered from mem_rdata.
  - Read latency from grant = 2 cycles, fixed.
  - CPU writes produce no rvalid.
  - Display and CPU reads may be back-to-back every cycle.
- Clear FSM:
  - States IDLE and RUN.
  - IDLE->RUN on clear_start: latch clear_color, clear_addr=0, clear_busy=1.
  - In RUN, each clear grant increments clear_addr.
  - A grant at clear_addr==FB_DEPTH-1 -> IDLE, with clear_done=1 the next cycle and clear_busy=0 in the same cycle as clear_done.
  - clear_start while RUN is ignored; the colour is not re-latched.
  - CPU writes during RUN are allowed and may be overwritten later by the clear if at a higher address; this is by design.
- disp_stall_cnt: 16-bit, saturates at 0xFFFF; does not wrap.
- Address width: clear_addr is ADDR_W bits and never exceeds FB_DEPTH-1.

Decomposition:
- Shared package vga_pkg: FB_DEPTH, H_ACTIVE=640, V_ACTIVE=480, the pixel-word typedef (DATA_W, RGB field positions) and the read-tag enum {TAG_NONE, TAG_DISP, TAG_CPU}.
- The clear engine (FSM plus address counter plus done pulse) is a natural sub-module: vga_fb_clear_engine.
- Arbitration and return pipeline stay in the top.

Test Plan:
- Display only: disp_req=1, addr 0..3 on consecutive cycles -> disp_gnt=1 every cycle; mem_addr 0..3 one cycle later; disp_rvalid with RAM data 2 cycles after each grant; disp_stall_cnt=0.
- Starvation: disp_req held 1, cpu_valid=1 read addr 0x100, MAX_WAIT=8 -> cpu_ready=0 for 8 cycles, 1 on 9th; disp_gnt=0 that cycle; disp_stall_cnt=1; cpu_rvalid 2 cycles later.
- CPU write then read: write 0x0ABC to addr 5 then read addr 5, no display -> accepted back-to-back; cpu_rvalid once with cpu_rdata=0x0ABC.
- Clear (FB_DEPTH overridden to 16): clear_start, color 0x0F00, no other traffic -> 16 writes to addrs 0..15 with 0x0F00; clear_done one pulse; clear_busy low after; second clear_start mid-run ignored.
- Clear with contention: display bursts during clear -> clear writes only in cycles with disp_req=0 and cpu_valid=0; all 16 addresses still written exactly once.
- Reset mid-clear at clear_addr=7: rst_n low asynchronously -> mem_en, clear_busy, rvalids drop immediately; no clear_done after release.
